// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shared memory port arbiter for fetch (I) and data (D) sides
// D side has priority; fetch is guaranteed a grant after DPRIO_MAX consecutive D grants.
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DPRIO_MAX = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_valid,
  output logic              o_if_stall,
  input  logic              i_mem_req,
  input  logic              i_mem_wen,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic              o_mem_valid,
  output logic              o_mem_stall,
  output logic              o_ram_cen,
  output logic              o_ram_wen,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  input  logic              i_ram_ready
);

  localparam logic [3:0] DPRIO = 4'(DPRIO_MAX);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              cen_q, cen_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic d_wins;

  // D wins unless fetch is waiting and has already been passed over DPRIO_MAX times.
  assign d_wins = i_mem_req && (!i_if_req || (starve_q < DPRIO));

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    cen_d    = cen_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (!i_if_req) begin
          starve_d = '0;
        end
        if (d_wins) begin
          state_d = BUSY_D;
          cen_d   = 1'b1;
          wen_d   = i_mem_wen;
          addr_d  = i_mem_addr;
          wdata_d = i_mem_wdata;
          if (i_if_req) begin
            starve_d = starve_q + 4'd1;
          end
        end else if (i_if_req) begin
          state_d  = BUSY_I;
          cen_d    = 1'b1;
          wen_d    = 1'b0;
          addr_d   = i_if_addr;
          wdata_d  = '0;
          starve_d = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (i_ram_ready) begin
          state_d = IDLE;
          cen_d   = 1'b0;
          wen_d   = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cen_d   = 1'b0;
        wen_d   = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      cen_q    <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      cen_q    <= cen_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign o_ram_cen   = cen_q;
  assign o_ram_wen   = wen_q;
  assign o_ram_addr  = addr_q;
  assign o_ram_wdata = wdata_q;

  // A requester that dropped its request mid-access still lets the access finish, but sees no valid.
  assign o_if_valid  = (state_q == BUSY_I) && i_ram_ready && i_if_req;
  assign o_mem_valid = (state_q == BUSY_D) && i_ram_ready && i_mem_req;

  assign o_if_rdata  = o_if_valid ? i_ram_rdata : '0;
  assign o_mem_rdata = (o_mem_valid && !wen_q) ? i_ram_rdata : '0;

  assign o_if_stall  = i_if_req && !o_if_valid;
  assign o_mem_stall = i_mem_req && !o_mem_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam logic [31:0] I_ADDR = 32'h0000_0100;
  localparam logic [31:0] D_ADDR = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic [31:0] o_if_rdata;
  logic        o_if_valid;
  logic        o_if_stall;
  logic        i_mem_req;
  logic        i_mem_wen;
  logic [31:0] i_mem_addr;
  logic [31:0] i_mem_wdata;
  logic [31:0] o_mem_rdata;
  logic        o_mem_valid;
  logic        o_mem_stall;
  logic        o_ram_cen;
  logic        o_ram_wen;
  logic [31:0] o_ram_addr;
  logic [31:0] o_ram_wdata;
  logic [31:0] i_ram_rdata;
  logic        i_ram_ready;

  int n_total = 0;
  int n_pass  = 0;

  mem_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .DPRIO_MAX(4)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .i_if_req   (i_if_req),
    .i_if_addr  (i_if_addr),
    .o_if_rdata (o_if_rdata),
    .o_if_valid (o_if_valid),
    .o_if_stall (o_if_stall),
    .i_mem_req  (i_mem_req),
    .i_mem_wen  (i_mem_wen),
    .i_mem_addr (i_mem_addr),
    .i_mem_wdata(i_mem_wdata),
    .o_mem_rdata(o_mem_rdata),
    .o_mem_valid(o_mem_valid),
    .o_mem_stall(o_mem_stall),
    .o_ram_cen  (o_ram_cen),
    .o_ram_wen  (o_ram_wen),
    .o_ram_addr (o_ram_addr),
    .o_ram_wdata(o_ram_wdata),
    .i_ram_rdata(i_ram_rdata),
    .i_ram_ready(i_ram_ready)
  );

  always #5 clk = ~clk;

  // Memory: unwritten words read a fixed pattern; wait states set by mw.
  logic [31:0]  mem [0:255];
  logic [255:0] written;
  logic         mem_clr;
  int           mw;
  logic [3:0]   wcnt;
  logic [7:0]   midx;

  assign midx        = o_ram_addr[9:2];
  assign i_ram_ready = o_ram_cen && (int'(wcnt) == mw);
  assign i_ram_rdata = written[midx] ? mem[midx] :
                       ((midx == 8'd0) ? 32'h2008_000A : {24'hA5A5A5, midx});

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                        wcnt <= '0;
    else if (!o_ram_cen || i_ram_ready) wcnt <= '0;
    else                              wcnt <= wcnt + 4'd1;
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      written <= '0;
    end else if (o_ram_cen && i_ram_ready && o_ram_wen) begin
      mem[midx]     <= o_ram_wdata;
      written[midx] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Both sides request reads continuously with zero-wait memory; checks the grant order.
  task automatic run_grants(input string tag, input int n, input logic [15:0] exp_i);
    int   got = 0;
    logic prev = 1'b0;
    logic is_i;
    for (int cyc = 0; cyc < 4 * n + 8 && got < n; cyc++) begin
      step();
      #1;
      is_i = o_ram_cen && (o_ram_addr == I_ADDR);
      if (o_ram_cen && !prev) begin
        check($sformatf("%s_grant%0d", tag, got), 32'(is_i), 32'(exp_i[got]));
        got++;
      end
      check($sformatf("%s_if_stall_c%0d", tag, cyc), 32'(o_if_stall), 32'(!is_i));
      prev = o_ram_cen;
    end
    if (got < n) check($sformatf("%s_timeout", tag), 32'(got), 32'(n));
  endtask

  logic [31:0] exp_rd [3];
  int          issued;

  initial begin
    exp_rd = '{32'h2008_000A, 32'hA5A5_A501, 32'hA5A5_A502};
    nrst = 1'b0; mem_clr = 1'b1; mw = 0;
    i_if_req = 1'b0; i_if_addr = '0;
    i_mem_req = 1'b0; i_mem_wen = 1'b0; i_mem_addr = '0; i_mem_wdata = '0;
    #1;
    check("rst_cen",     32'(o_ram_cen), 0);
    check("rst_wen",     32'(o_ram_wen), 0);
    check("rst_addr",    o_ram_addr, 0);
    check("rst_wdata",   o_ram_wdata, 0);
    check("rst_ifvalid", 32'(o_if_valid), 0);
    check("rst_mvalid",  32'(o_mem_valid), 0);
    check("rst_ifrdata", o_if_rdata, 0);
    check("rst_mstall",  32'(o_mem_stall), 0);
    i_if_req = 1'b1;
    #1;
    check("rst_ifstall_follows_req", 32'(o_if_stall), 1);
    i_if_req = 1'b0;
    step(); step();
    mem_clr = 1'b0;
    nrst = 1'b1;

    // I-only zero-wait read of 0x0
    i_if_req = 1'b1; i_if_addr = 32'h0;
    #1;
    check("t1_c0_stall", 32'(o_if_stall), 1);
    check("t1_c0_cen",   32'(o_ram_cen), 0);
    step();
    check("t1_c1_cen",   32'(o_ram_cen), 1);
    check("t1_c1_valid", 32'(o_if_valid), 1);
    check("t1_c1_rdata", o_if_rdata, 32'h2008_000A);
    check("t1_c1_stall", 32'(o_if_stall), 0);
    step();
    i_if_req = 1'b0;
    #1;
    check("t1_c2_cen",   32'(o_ram_cen), 0);
    check("t1_c2_valid", 32'(o_if_valid), 0);

    // D write 0x10 with two wait states, then readback
    mw = 2;
    i_mem_req = 1'b1; i_mem_wen = 1'b1; i_mem_addr = 32'h10; i_mem_wdata = 32'hDEAD_BEEF;
    #1;
    check("t2_c0_stall", 32'(o_mem_stall), 1);
    for (int c = 1; c <= 3; c++) begin
      step();
      check($sformatf("t2_c%0d_wen", c),   32'(o_ram_wen), 1);
      check($sformatf("t2_c%0d_valid", c), 32'(o_mem_valid), 32'(c == 3));
      check($sformatf("t2_c%0d_wdata", c), o_ram_wdata, 32'hDEAD_BEEF);
      if (c == 3) check("t2_c3_rdata", o_mem_rdata, 0);
    end
    step();
    i_mem_req = 1'b0; i_mem_wen = 1'b0;
    #1;
    check("t2_idle_wen", 32'(o_ram_wen), 0);
    check("t2_idle_cen", 32'(o_ram_cen), 0);
    mw = 0;
    step();
    i_mem_req = 1'b1;
    step();
    check("t2_rb_valid", 32'(o_mem_valid), 1);
    check("t2_rb_rdata", o_mem_rdata, 32'hDEAD_BEEF);
    step();
    i_mem_req = 1'b0;

    // Continuous contention: D,D,D,D,I,D,D,D,D,I
    i_if_addr = I_ADDR; i_mem_addr = D_ADDR; i_mem_wen = 1'b0;
    step();
    i_if_req = 1'b1; i_mem_req = 1'b1;
    run_grants("t3", 10, 16'h0210);
    step();
    i_if_req = 1'b0; i_mem_req = 1'b0;

    // D drops after two grants; I follows, then starve count restarts from 0
    step();
    i_if_req = 1'b1; i_mem_req = 1'b1;
    run_grants("t4", 2, 16'h0000);
    step();
    i_mem_req = 1'b0;
    #1;
    check("t4_idle_cen",   32'(o_ram_cen), 0);
    check("t4_idle_stall", 32'(o_if_stall), 1);
    step();
    check("t4_i_cen",   32'(o_ram_cen), 1);
    check("t4_i_addr",  o_ram_addr, I_ADDR);
    check("t4_i_valid", 32'(o_if_valid), 1);
    step();
    i_mem_req = 1'b1;
    run_grants("t4r", 5, 16'h0010);
    step();
    i_if_req = 1'b0; i_mem_req = 1'b0;

    // Reset mid BUSY_D with three wait states
    step();
    mw = 3;
    i_mem_req = 1'b1; i_mem_addr = 32'h10;
    step();
    check("t5_cen_before", 32'(o_ram_cen), 1);
    step();
    nrst = 1'b0;
    #1;
    check("t5_rst_cen",   32'(o_ram_cen), 0);
    check("t5_rst_addr",  o_ram_addr, 0);
    check("t5_rst_valid", 32'(o_mem_valid), 0);
    step();
    check("t5_rst2_valid", 32'(o_mem_valid), 0);
    nrst = 1'b1;
    #1;
    check("t5_rel_cen", 32'(o_ram_cen), 0);
    step();
    check("t5_regrant_cen",  32'(o_ram_cen), 1);
    check("t5_regrant_addr", o_ram_addr, 32'h10);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("t5_k%0d_valid", k), 32'(o_mem_valid), 32'(k == 3));
    end
    check("t5_rdata", o_mem_rdata, 32'hDEAD_BEEF);
    step();
    i_mem_req = 1'b0;
    mw = 0;

    // Back-to-back I reads of 0x0, 0x4, 0x8
    step();
    i_if_req = 1'b1; i_if_addr = 32'h0;
    #1;
    check("t6_c0_stall", 32'(o_if_stall), 1);
    issued = 0;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 2 || c == 4) i_if_addr = 32'(c * 2);
      if (c == 6) i_if_req = 1'b0;
      #1;
      if (o_ram_cen) issued++;
      if (c % 2 == 1) begin
        check($sformatf("t6_c%0d_valid", c), 32'(o_if_valid), 1);
        check($sformatf("t6_c%0d_addr", c),  o_ram_addr, 32'((c - 1) * 2));
        check($sformatf("t6_c%0d_rdata", c), o_if_rdata, exp_rd[(c - 1) / 2]);
      end else begin
        check($sformatf("t6_c%0d_cen", c),   32'(o_ram_cen), 0);
        check($sformatf("t6_c%0d_stall", c), 32'(o_if_stall), 32'(c < 6));
      end
    end
    check("t6_issued", 32'(issued), 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
